regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, replacing the fixed 32×32 two-read register file. It provides NUM_READ combinational read ports with same-cycle write bypass, a primary write port, and a dedicated link write port for jal. It also keeps a per-register pending scoreboard so decode can stall on outstanding multi-cycle (load) results, and a registered debug read port. It sits between decode and writeback.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_bypass.sv | 45 ++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS multi-port register file and its callers.
package regfile_pkg;

    localparam logic [31:0] SP_INIT_DEF  = 32'h7fffeffc;
    localparam int          SP_REG_DEF   = 29;
    localparam int          LINK_REG_DEF = 31;
    localparam int          ZERO_REG     = 0;

    // Jump modes decoded by the caller; jal drives link_en.
    typedef enum logic [1:0] {
        JMP_NONE    = 2'b00,
        JMP_JR_LINK = 2'b01,
        JMP_JAL     = 2'b11
    } jmp_mode_e;

endpackage

// File: rtl/regfile_bypass.sv
// One read port: zero-register, link/primary write bypass and pending-stall logic.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              pend_bit,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_stall
);

    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic is_zero;
    logic link_hit;
    logic wr_hit;

    always_comb begin
        is_zero  = (rd_addr == ZERO_A);
        link_hit = link_en && (rd_addr == LINK_A);
        wr_hit   = wr_en && (rd_addr == wr_addr);
        rd_data  = stored_data;
        // A result arriving this cycle resolves the pending load, so no stall.
        rd_stall = pend_bit && !link_hit && !wr_hit;
        if (is_zero) begin
            rd_data  = '0;
            rd_stall = 1'b0;
        end else if (link_hit) begin
            rd_data = link_data;
        end else if (wr_hit) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: NUM_READ bypassed read ports, write + link ports,
// per-register pending scoreboard and a registered debug read port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_READ = 2,
    parameter int                SP_REG   = SP_REG_DEF,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
    parameter int                LINK_REG = LINK_REG_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_stall,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         link_en,
    input  logic [DATA_W-1:0]            link_data,
    input  logic                         pend_set,
    input  logic [ADDR_W-1:0]            pend_addr,
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DATA_W-1:0] dbg_data_q;
    logic [DATA_W-1:0] dbg_data_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        if (wr_en) regs_d[wr_addr] = wr_data;
        // Link write is applied last so it overrides a primary write to LINK_REG.
        if (link_en) regs_d[LINK_A] = link_data;
        regs_d[ZERO_A] = '0;
    end

    always_comb begin
        pend_d = pend_q;
        if (wr_en)    pend_d[wr_addr] = 1'b0;
        if (link_en)  pend_d[LINK_A]  = 1'b0;
        // Set after clears: a newly issued load outranks an older result.
        if (pend_set) pend_d[pend_addr] = 1'b1;
        pend_d[ZERO_A] = 1'b0;
    end

    always_comb begin
        dbg_data_d = regs_q[dbg_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_REG) ? SP_INIT : '0;
            end
            pend_q     <= '0;
            dbg_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            pend_q     <= pend_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign dbg_data = dbg_data_q;

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        regfile_bypass #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .LINK_REG (LINK_REG)
        ) u_bypass (
            .rd_addr     (addr),
            .stored_data (regs_q[addr]),
            .pend_bit    (pend_q[addr]),
            .link_en     (link_en),
            .link_data   (link_data),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rd_data     (rd_data[g*DATA_W +: DATA_W]),
            .rd_stall    (rd_stall[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed test of regfile_mp (4 read ports): reset, bypass, link priority, scoreboard, debug port.
module tb_regfile_mp;

    localparam int NR = 4;
    localparam logic [31:0] SP = 32'h7fffeffc;

    logic              clock;
    logic              reset;
    logic [NR*5-1:0]   rd_addr;
    logic [NR*32-1:0]  rd_data;
    logic [NR-1:0]     rd_stall;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              link_en;
    logic [31:0]       link_data;
    logic              pend_set;
    logic [4:0]        pend_addr;
    logic [4:0]        dbg_addr;
    logic [31:0]       dbg_data;

    int nvec = 0;
    int nerr = 0;

    regfile_mp #(.NUM_READ(NR)) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_stall  (rd_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rdp(int p);
        return rd_data[p*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        link_en = 0; link_data = '0; pend_set = 0; pend_addr = '0; dbg_addr = '0;
        #2;
        // Reset state, read combinationally while reset is held.
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a));
            #1;
            chk($sformatf("rst_r%0d", a), rdp(0), (a == 29) ? SP : 32'h0);
        end
        chk("rst_stall", {28'h0, rd_stall}, 32'h0);
        chk("rst_dbg", dbg_data, 32'h0);

        @(negedge clock);
        reset = 1'b1;
        dbg_addr = 5'd29;
        step;
        chk("dbg_sp", dbg_data, SP);

        // Same-cycle write bypass, then stored value.
        wr_en = 1; wr_addr = 5'd8; wr_data = 32'hdeadbeef; set_rd(0, 5'd8);
        #1 chk("byp_r8", rdp(0), 32'hdeadbeef);
        step; wr_en = 0;
        #1 chk("st_r8", rdp(0), 32'hdeadbeef);

        // Writes to r0 are dropped.
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'h1234; set_rd(0, 5'd0);
        #1 chk("byp_r0", rdp(0), 32'h0);
        step; wr_en = 0;
        #1 chk("st_r0", rdp(0), 32'h0);

        // Link beats primary write on r31.
        link_en = 1; link_data = 32'h00400010; wr_en = 1; wr_addr = 5'd31; wr_data = 32'h5;
        set_rd(1, 5'd31);
        #1 chk("byp_link", rdp(1), 32'h00400010);
        step; link_en = 0; wr_en = 0;
        #1 chk("st_link", rdp(1), 32'h00400010);

        // Scoreboard on r9.
        pend_set = 1; pend_addr = 5'd9;
        step; pend_set = 0; set_rd(0, 5'd9); set_rd(2, 5'd9);
        #1 chk("pend_s0", {31'h0, rd_stall[0]}, 32'h1);
        chk("pend_s2", {31'h0, rd_stall[2]}, 32'h1);
        wr_en = 1; wr_addr = 5'd9; wr_data = 32'h77;
        #1 chk("res_s0", {31'h0, rd_stall[0]}, 32'h0);
        chk("res_d0", rdp(0), 32'h77);
        step; wr_en = 0;
        #1 chk("clr_s0", {31'h0, rd_stall[0]}, 32'h0);
        chk("clr_d0", rdp(0), 32'h77);
        pend_set = 1; pend_addr = 5'd9; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h88;
        step; pend_set = 0; wr_en = 0;
        #1 chk("setwin_s0", {31'h0, rd_stall[0]}, 32'h1);
        chk("setwin_d0", rdp(0), 32'h88);

        // Link clears r31 pending; r0 is never pending.
        pend_set = 1; pend_addr = 5'd31;
        step; pend_set = 0;
        #1 chk("pend31", {31'h0, rd_stall[1]}, 32'h1);
        link_en = 1; link_data = 32'h00400020;
        #1 chk("link_res", {31'h0, rd_stall[1]}, 32'h0);
        step; link_en = 0;
        #1 chk("link_clr", {31'h0, rd_stall[1]}, 32'h0);
        pend_set = 1; pend_addr = 5'd0; set_rd(3, 5'd0);
        step; pend_set = 0;
        #1 chk("pend_r0", {31'h0, rd_stall[3]}, 32'h0);

        // Debug port has one cycle latency and no bypass.
        wr_en = 1; wr_addr = 5'd10; wr_data = 32'h55; dbg_addr = 5'd10;
        step; wr_en = 0;
        chk("dbg_nobyp", dbg_data, 32'h0);
        step;
        chk("dbg_r10", dbg_data, 32'h55);

        // Mid-cycle reset discards state and in-flight write.
        pend_set = 1; pend_addr = 5'd6;
        step; pend_set = 0; set_rd(0, 5'd5); set_rd(1, 5'd6); set_rd(2, 5'd29); set_rd(3, 5'd8);
        #1 chk("pend_r6", {31'h0, rd_stall[1]}, 32'h1);
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hA;
        #2 reset = 1'b0; wr_en = 0;
        #1 chk("mrst_r5", rdp(0), 32'h0);
        chk("mrst_s6", {31'h0, rd_stall[1]}, 32'h0);
        chk("mrst_sp", rdp(2), SP);
        chk("mrst_r8", rdp(3), 32'h0);
        chk("mrst_dbg", dbg_data, 32'h0);
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hA;
        step; wr_en = 0;
        #1 chk("rsthold_r5", rdp(0), 32'h0);
        reset = 1'b1;
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hA;
        step; wr_en = 0;
        #1 chk("post_r5", rdp(0), 32'hA);

        // Four independent read ports.
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
            step;
        end
        wr_en = 0;
        set_rd(0, 5'd4); set_rd(1, 5'd2); set_rd(2, 5'd29); set_rd(3, 5'd1);
        #1 chk("p0_r4", rdp(0), 32'h1004);
        chk("p1_r2", rdp(1), 32'h1002);
        chk("p2_sp", rdp(2), SP);
        chk("p3_r1", rdp(3), 32'h1001);
        set_rd(0, 5'd3); set_rd(3, 5'd5);
        #1 chk("p0_r3", rdp(0), 32'h1003);
        chk("p3_r5", rdp(3), 32'hA);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
